// File: rtl/frog_collision_ctrl.sv
// ---------------------------------------------------------------------------
// frog_collision_ctrl
//
// Game-rule stage that sits after the per-lane car movers. Each clock it
// checks whether the frog shares a cell with any lane's car. On a collision
// it takes a life and freezes play for a fixed number of clocks. When the
// frog reaches the goal row it advances the level. The level it produces is
// fed back to every car mover.
//
// Ports
//   i_Clk          system clock
//   i_Rst_n        asynchronous active-low reset
//   i_car_x_flat   lane k car X position in bits [5k+4:5k]
//   i_frog_x       frog column
//   i_frog_y       frog row
//   i_start        one-cycle pulse that restarts the game from GAME_OVER
//   o_level        current level (1..MAX_LEVEL)
//   o_lives        remaining lives
//   o_hit          one-clock pulse on a collision
//   o_frog_reset   one-clock pulse telling the frog to return to its start
//   o_game_over    high while in GAME_OVER
//   o_state        PLAY=0, HIT=1, WIN=2, GAME_OVER=3
// ---------------------------------------------------------------------------
module frog_collision_ctrl #(
  parameter int NUM_LANES   = 4,
  parameter int LANE_Y0     = 2,
  parameter int GOAL_Y      = 0,
  parameter int GRID_W      = 20,
  parameter int CAR_LEN     = 2,
  parameter int START_LIVES = 3,
  parameter int MAX_LEVEL   = 15,
  parameter int HIT_HOLD    = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic [5*NUM_LANES-1:0] i_car_x_flat,
  input  logic [4:0]             i_frog_x,
  input  logic [3:0]             i_frog_y,
  input  logic                   i_start,
  output logic [3:0]             o_level,
  output logic [2:0]             o_lives,
  output logic                   o_hit,
  output logic                   o_frog_reset,
  output logic                   o_game_over,
  output logic [1:0]             o_state
);

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_HIT       = 2'd1,
    ST_WIN       = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  // The hold counter runs 0..HIT_HOLD-1 while in HIT.
  localparam int CNT_W = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

  state_t           r_state;
  logic [3:0]       r_level;
  logic [2:0]       r_lives;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hit;
  logic             r_frogReset;

  state_t           w_stateNext;
  logic [3:0]       w_levelNext;
  logic [2:0]       w_livesNext;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_hitNext;
  logic             w_frogResetNext;

  logic             w_hit;
  logic             w_goal;
  logic [5:0]       w_car;
  logic [5:0]       w_cell;

  // Collision detect. A car covers CAR_LEN cells starting at its X and
  // wraps past the right edge. Off-grid car or frog positions never collide.
  always_comb begin
    w_hit  = 1'b0;
    w_car  = 6'd0;
    w_cell = 6'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_car = {1'b0, i_car_x_flat[5*k +: 5]};
      if ((i_frog_y == 4'(LANE_Y0 + k)) &&
          (w_car < 6'(GRID_W)) &&
          ({1'b0, i_frog_x} < 6'(GRID_W))) begin
        for (int j = 0; j < CAR_LEN; j++) begin
          w_cell = w_car + 6'(j);
          if (w_cell >= 6'(GRID_W)) begin
            w_cell = w_cell - 6'(GRID_W);
          end
          if (w_cell[4:0] == i_frog_x) begin
            w_hit = 1'b1;
          end
        end
      end
    end
  end

  assign w_goal = (i_frog_y == 4'(GOAL_Y));

  // Next-state and next-output logic. A collision takes priority over
  // reaching the goal. HIT ignores every input until the hold expires.
  always_comb begin
    w_stateNext     = r_state;
    w_levelNext     = r_level;
    w_livesNext     = r_lives;
    w_cntNext       = r_cnt;
    w_hitNext       = 1'b0;
    w_frogResetNext = 1'b0;
    case (r_state)
      ST_PLAY: begin
        if (w_hit) begin
          w_stateNext = ST_HIT;
          w_hitNext   = 1'b1;
          w_livesNext = r_lives - 3'd1;
          w_cntNext   = '0;
        end else if (w_goal) begin
          w_stateNext = ST_WIN;
        end
      end
      ST_HIT: begin
        if (r_cnt == CNT_W'(HIT_HOLD - 1)) begin
          w_cntNext       = '0;
          w_frogResetNext = 1'b1;
          w_stateNext     = (r_lives == 3'd0) ? ST_GAME_OVER : ST_PLAY;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      ST_WIN: begin
        if (r_level < 4'(MAX_LEVEL)) begin
          w_levelNext = r_level + 4'd1;
        end
        w_frogResetNext = 1'b1;
        w_stateNext     = ST_PLAY;
      end
      ST_GAME_OVER: begin
        if (i_start) begin
          w_stateNext     = ST_PLAY;
          w_levelNext     = 4'd1;
          w_livesNext     = 3'(START_LIVES);
          w_frogResetNext = 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_PLAY;
      end
    endcase
  end

  // State and registered outputs. Reset aborts any HIT or WIN in progress.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state     <= ST_PLAY;
      r_level     <= 4'd1;
      r_lives     <= 3'(START_LIVES);
      r_cnt       <= '0;
      r_hit       <= 1'b0;
      r_frogReset <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_level     <= w_levelNext;
      r_lives     <= w_livesNext;
      r_cnt       <= w_cntNext;
      r_hit       <= w_hitNext;
      r_frogReset <= w_frogResetNext;
    end
  end

  assign o_level      = r_level;
  assign o_lives      = r_lives;
  assign o_hit        = r_hit;
  assign o_frog_reset = r_frogReset;
  assign o_game_over  = (r_state == ST_GAME_OVER);
  assign o_state      = r_state;

endmodule

// File: tb/tb_frog_collision_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frog_collision_ctrl
//
// Directed testbench for frog_collision_ctrl. It covers reset, a plain hit
// and its hold, wrap-around collisions, level stepping with saturation,
// game over and restart, and reset asserted in the middle of a hit hold.
// ---------------------------------------------------------------------------
module tb_frog_collision_ctrl;

  logic        clk;
  logic        rst_n;
  logic [19:0] carXFlat;
  logic [4:0]  frogX;
  logic [3:0]  frogY;
  logic        start;
  logic [3:0]  level;
  logic [2:0]  lives;
  logic        hit;
  logic        frogReset;
  logic        gameOver;
  logic [1:0]  state;

  int passCount  = 0;
  int checkCount = 0;

  frog_collision_ctrl dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_car_x_flat (carXFlat),
    .i_frog_x     (frogX),
    .i_frog_y     (frogY),
    .i_start      (start),
    .o_level      (level),
    .o_lives      (lives),
    .o_hit        (hit),
    .o_frog_reset (frogReset),
    .o_game_over  (gameOver),
    .o_state      (state)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack four lane X positions, lane 0 in the low bits.
  function automatic logic [19:0] cars(input logic [4:0] c0, input logic [4:0] c1,
                                       input logic [4:0] c2, input logic [4:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Drive all inputs at once.
  task automatic applyStimulus(input logic [19:0] cx, input logic [4:0] fx,
                               input logic [3:0] fy, input logic st);
    carXFlat = cx;
    frogX    = fx;
    frogY    = fy;
    start    = st;
  endtask

  // Frog on a row that is neither a lane nor the goal.
  task automatic applyIdle();
    applyStimulus(cars(5'd10, 5'd10, 5'd10, 5'd10), 5'd5, 4'd10, 1'b0);
  endtask

  // Frog on lane 1 (row 3) at x=8, car at x=7 covering 7 and 8.
  task automatic applyHit();
    applyStimulus(cars(5'd10, 5'd7, 5'd10, 5'd10), 5'd8, 4'd3, 1'b0);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Main stimulus sequence.
  initial begin
    int lvl;
    rst_n = 1'b0;
    applyIdle();

    // 1 Reset values.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_level", level, 1);
    checkOutput("rst_lives", lives, 3);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_hit", hit, 0);
    checkOutput("rst_frog_reset", frogReset, 0);
    checkOutput("rst_game_over", gameOver, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // i_start outside GAME_OVER does nothing.
    applyStimulus(cars(5'd10, 5'd10, 5'd10, 5'd10), 5'd5, 4'd10, 1'b1);
    tick();
    checkOutput("start_ign_state", state, 0);
    checkOutput("start_ign_frog_reset", frogReset, 0);
    applyIdle();
    tick();
    checkOutput("idle_hit", hit, 0);

    // 2 Basic hit and hold.
    applyHit();
    tick();
    checkOutput("hit_pulse", hit, 1);
    checkOutput("hit_lives", lives, 2);
    checkOutput("hit_state", state, 1);
    applyIdle();
    tick();
    checkOutput("hit_pulse_width", hit, 0);
    repeat (6) tick();
    checkOutput("hold7_state", state, 1);
    checkOutput("hold7_frog_reset", frogReset, 0);
    tick();
    checkOutput("hold8_frog_reset", frogReset, 1);
    checkOutput("hold8_state", state, 0);
    tick();
    checkOutput("hold_frog_reset_width", frogReset, 0);

    // 3 Wrap-around and off-grid cases on lane 0 (row 2).
    applyStimulus(cars(5'd19, 5'd10, 5'd10, 5'd10), 5'd1, 4'd2, 1'b0);
    tick();
    checkOutput("wrap_x1_hit", hit, 0);
    applyStimulus(cars(5'd19, 5'd10, 5'd10, 5'd10), 5'd25, 4'd2, 1'b0);
    tick();
    checkOutput("frog_offgrid_hit", hit, 0);
    applyStimulus(cars(5'd20, 5'd10, 5'd10, 5'd10), 5'd0, 4'd2, 1'b0);
    tick();
    checkOutput("car_offgrid_hit", hit, 0);
    checkOutput("car_offgrid_state", state, 0);
    applyStimulus(cars(5'd19, 5'd10, 5'd10, 5'd10), 5'd0, 4'd2, 1'b0);
    tick();
    checkOutput("wrap_x0_hit", hit, 1);
    checkOutput("wrap_x0_lives", lives, 1);
    applyIdle();
    repeat (8) tick();
    checkOutput("wrap_back_to_play", state, 0);

    // 4 Level stepping and saturation.
    doReset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(cars(5'd10, 5'd10, 5'd10, 5'd10), 5'd5, 4'd0, 1'b0);
      tick();
      checkOutput("win_state", state, 2);
      applyIdle();
      tick();
      lvl = (i + 2 > 15) ? 15 : i + 2;
      checkOutput("win_level", level, lvl);
      checkOutput("win_frog_reset", frogReset, 1);
      checkOutput("win_lives", lives, 3);
      tick();
      checkOutput("win_frog_reset_width", frogReset, 0);
    end

    // 5 Game over and restart.
    doReset();
    applyStimulus(cars(5'd10, 5'd10, 5'd10, 5'd10), 5'd5, 4'd0, 1'b0);
    tick();
    applyIdle();
    tick();
    checkOutput("go_pre_level", level, 2);
    for (int h = 0; h < 3; h++) begin
      applyHit();
      tick();
      checkOutput("go_hit", hit, 1);
      checkOutput("go_lives", lives, 2 - h);
      applyIdle();
      repeat (7) tick();
      tick();
      checkOutput("go_hold_frog_reset", frogReset, 1);
      checkOutput("go_after_hold_state", state, (h < 2) ? 0 : 3);
    end
    checkOutput("go_flag", gameOver, 1);
    applyHit();
    repeat (4) tick();
    checkOutput("go_hold_state", state, 3);
    checkOutput("go_hold_lives", lives, 0);
    checkOutput("go_hold_hit", hit, 0);
    checkOutput("go_hold_level", level, 2);
    applyStimulus(cars(5'd10, 5'd10, 5'd10, 5'd10), 5'd5, 4'd10, 1'b1);
    tick();
    start = 1'b0;
    checkOutput("restart_state", state, 0);
    checkOutput("restart_level", level, 1);
    checkOutput("restart_lives", lives, 3);
    checkOutput("restart_frog_reset", frogReset, 1);
    checkOutput("restart_game_over", gameOver, 0);
    tick();
    checkOutput("restart_frog_reset_width", frogReset, 0);

    // 6 Reset in the middle of a hit hold.
    applyHit();
    tick();
    checkOutput("mid_hit_lives", lives, 2);
    applyIdle();
    repeat (4) tick();
    checkOutput("mid_hit_state", state, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_state", state, 0);
    checkOutput("mid_rst_lives", lives, 3);
    checkOutput("mid_rst_level", level, 1);
    checkOutput("mid_rst_hit", hit, 0);
    checkOutput("mid_rst_frog_reset", frogReset, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("post_rst_frog_reset", frogReset, 0);
    end
    checkOutput("post_rst_state", state, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
